// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer presenting the oldest
// instruction to decode with fields extracted and immediate extended.

module imm_extend (
   input  logic [24:0] instr_i,
   input  logic [2:0]  imm_src_i,
   output logic [31:0] imm_ext_o
);
   // instr_i holds instr[31:7]; formats are 0=I, 1=S, 2=B, 3=J, 4=U
   always_comb begin
      imm_ext_o = '0;
      case (imm_src_i)
         3'd0: imm_ext_o = {{20{instr_i[24]}}, instr_i[24:13]};
         3'd1: imm_ext_o = {{20{instr_i[24]}}, instr_i[24:18], instr_i[4:0]};
         3'd2: imm_ext_o = {{20{instr_i[24]}}, instr_i[0], instr_i[23:18], instr_i[4:1], 1'b0};
         3'd3: imm_ext_o = {{12{instr_i[24]}}, instr_i[12:5], instr_i[13], instr_i[23:14], 1'b0};
         3'd4: imm_ext_o = {instr_i[24:5], 12'b0};
         default: imm_ext_o = '0;
      endcase
   end
endmodule

module decode_queue #(
   parameter int  DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic             valid_f_i,
   input  logic [31:0]      instr_f_i,
   input  logic [31:0]      pc_f_i,
   input  logic [31:0]      pc_plus4_f_i,
   input  logic [31:0]      pred_pc_target_f_i,
   input  logic             pc_src_pred_f_i,
   output logic             ready_f_o,
   input  logic [2:0]       imm_src_d_i,
   input  logic             stall_d_i,
   input  logic             flush_d_i,
   output logic             valid_d_o,
   output logic [31:0]      instr_d_o,
   output logic [31:0]      pc_d_o,
   output logic [31:0]      pc_plus4_d_o,
   output logic [31:0]      pred_pc_target_d_o,
   output logic [31:0]      imm_ext_d_o,
   output logic             pc_src_pred_d_o,
   output logic [4:0]       rd_d_o,
   output logic [4:0]       rs1_d_o,
   output logic [4:0]       rs2_d_o,
   output logic [6:0]       op_d_o,
   output logic [2:0]       funct3_d_o,
   output logic [6:0]       funct7_d_o,
   output logic [CNT_W-1:0] occupancy_o
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] pred_target;
      logic        pc_src_pred;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   // ready looks only at the registered count, so stall never reaches fetch combinationally
   assign ready_f_o   = (count != CNT_W'(DEPTH));
   assign valid_d_o   = (count != '0);
   assign push        = valid_f_i & ready_f_o;
   assign pop         = valid_d_o & ~stall_d_i;
   assign occupancy_o = count;

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= '{instr: instr_f_i, pc: pc_f_i, pc_plus4: pc_plus4_f_i,
                          pred_target: pred_pc_target_f_i, pc_src_pred: pc_src_pred_f_i};
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_d_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CNT_W'(1);
         else if (pop && !push) count <= count - CNT_W'(1);
      end
   end

   always_comb begin
      head = '0;
      if (valid_d_o) head = mem[rd_ptr];
   end

   assign instr_d_o          = head.instr;
   assign pc_d_o             = head.pc;
   assign pc_plus4_d_o       = head.pc_plus4;
   assign pred_pc_target_d_o = head.pred_target;
   assign pc_src_pred_d_o    = head.pc_src_pred;
   assign rd_d_o             = head.instr[11:7];
   assign rs1_d_o            = head.instr[19:15];
   assign rs2_d_o            = head.instr[24:20];
   assign op_d_o             = head.instr[6:0];
   assign funct3_d_o         = head.instr[14:12];
   assign funct7_d_o         = head.instr[31:25];

   imm_extend u_imm_extend (
      .instr_i   (instr_d_o[31:7]),
      .imm_src_i (imm_src_d_i),
      .imm_ext_o (imm_ext_d_o)
   );
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: model queue tracks pushes, head compared on each pop.
`timescale 1ns/1ps
module tb_decode_queue;
   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic             clk_i = 1'b0;
   logic             reset_n_i;
   logic             valid_f_i;
   logic [31:0]      instr_f_i, pc_f_i, pc_plus4_f_i, pred_pc_target_f_i;
   logic             pc_src_pred_f_i;
   logic             ready_f_o;
   logic [2:0]       imm_src_d_i;
   logic             stall_d_i, flush_d_i;
   logic             valid_d_o;
   logic [31:0]      instr_d_o, pc_d_o, pc_plus4_d_o, pred_pc_target_d_o, imm_ext_d_o;
   logic             pc_src_pred_d_o;
   logic [4:0]       rd_d_o, rs1_d_o, rs2_d_o;
   logic [6:0]       op_d_o, funct7_d_o;
   logic [2:0]       funct3_d_o;
   logic [CNT_W-1:0] occupancy_o;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   decode_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_f_i(valid_f_i), .instr_f_i(instr_f_i),
      .pc_f_i(pc_f_i), .pc_plus4_f_i(pc_plus4_f_i), .pred_pc_target_f_i(pred_pc_target_f_i),
      .pc_src_pred_f_i(pc_src_pred_f_i), .ready_f_o(ready_f_o), .imm_src_d_i(imm_src_d_i),
      .stall_d_i(stall_d_i), .flush_d_i(flush_d_i), .valid_d_o(valid_d_o),
      .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pc_plus4_d_o(pc_plus4_d_o),
      .pred_pc_target_d_o(pred_pc_target_d_o), .imm_ext_d_o(imm_ext_d_o),
      .pc_src_pred_d_o(pc_src_pred_d_o), .rd_d_o(rd_d_o), .rs1_d_o(rs1_d_o),
      .rs2_d_o(rs2_d_o), .op_d_o(op_d_o), .funct3_d_o(funct3_d_o),
      .funct7_d_o(funct7_d_o), .occupancy_o(occupancy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc);
      valid_f_i          = vld;
      instr_f_i          = instr;
      pc_f_i             = pc;
      pc_plus4_f_i       = pc + 32'd4;
      pred_pc_target_f_i = pc ^ 32'hA5A5_0000;
      pc_src_pred_f_i    = pc[2];
   endtask

   // One clock: check state against the model, retire/accept into the model, then advance.
   task automatic step();
      logic exp_rdy;
      logic exp_vld;
      exp_t e;
      exp_rdy = (sb.size() != DEPTH);
      exp_vld = (sb.size() != 0);
      total++;
      if (occupancy_o !== CNT_W'(sb.size())) begin
         bad++; $display("FAIL occupancy got=%0d want=%0d", occupancy_o, sb.size());
      end
      total++;
      if (ready_f_o !== exp_rdy) begin
         bad++; $display("FAIL ready_f got=%b want=%b", ready_f_o, exp_rdy);
      end
      total++;
      if (valid_d_o !== exp_vld) begin
         bad++; $display("FAIL valid_d got=%b want=%b", valid_d_o, exp_vld);
      end
      if (exp_vld && !stall_d_i && !flush_d_i) begin
         e = sb.pop_front();
         total++;
         if (instr_d_o !== e.instr || pc_d_o !== e.pc || pc_plus4_d_o !== e.pc + 32'd4 ||
             pred_pc_target_d_o !== (e.pc ^ 32'hA5A5_0000) || pc_src_pred_d_o !== e.pc[2]) begin
            bad++;
            $display("FAIL head_order got instr=%h pc=%h pc4=%h tgt=%h bp=%b want instr=%h pc=%h",
                     instr_d_o, pc_d_o, pc_plus4_d_o, pred_pc_target_d_o, pc_src_pred_d_o,
                     e.instr, e.pc);
         end
      end
      if (flush_d_i) sb.delete();
      else if (valid_f_i && exp_rdy) sb.push_back('{instr: instr_f_i, pc: pc_f_i});
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      drive(1'b0, 32'h0, 32'h0);
      stall_d_i = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) step();
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      drive(1'b1, 32'hDEAD_BEEF, 32'h40);
      stall_d_i = 1'b0; flush_d_i = 1'b0; imm_src_d_i = 3'd0;
      repeat (3) @(posedge clk_i);
      #1;
      total++;
      if (valid_d_o !== 1'b0 || ready_f_o !== 1'b1 || occupancy_o !== '0 || instr_d_o !== '0) begin
         bad++;
         $display("FAIL reset_state got vld=%b rdy=%b occ=%0d instr=%h want 0/1/0/0",
                  valid_d_o, ready_f_o, occupancy_o, instr_d_o);
      end
      drive(1'b0, 32'h0, 32'h0);
      reset_n_i = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_first_push();
      drive(1'b1, 32'h0050_0093, 32'h100);
      stall_d_i = 1'b1;
      step();
      drive(1'b0, 32'h0, 32'h0);
      total++;
      if (valid_d_o !== 1'b1 || rd_d_o !== 5'd1 || rs1_d_o !== 5'd0 || op_d_o !== 7'h13 ||
          pc_d_o !== 32'h100 || imm_ext_d_o !== 32'd5) begin
         bad++;
         $display("FAIL first_push got vld=%b rd=%0d rs1=%0d op=%h pc=%h imm=%h",
                  valid_d_o, rd_d_o, rs1_d_o, op_d_o, pc_d_o, imm_ext_d_o);
      end
      drain();
   endtask

   task automatic test_imm();
      logic [31:0] instrs [4];
      logic [2:0]  srcs   [4];
      logic [31:0] imms   [4];
      instrs = '{32'h0051_2423, 32'hFE00_0EE3, 32'h0080_006F, 32'h1234_50B7};
      srcs   = '{3'd1, 3'd2, 3'd3, 3'd4};
      imms   = '{32'd8, 32'hFFFF_FFFC, 32'd8, 32'h1234_5000};
      for (int i = 0; i < 4; i++) begin
         stall_d_i = 1'b1;
         drive(1'b1, instrs[i], 32'h200 + 32'(i * 4));
         step();
         drive(1'b0, 32'h0, 32'h0);
         imm_src_d_i = srcs[i];
         #1;
         total++;
         if (imm_ext_d_o !== imms[i]) begin
            bad++; $display("FAIL imm_ext[%0d] got=%h want=%h", i, imm_ext_d_o, imms[i]);
         end
         if (i == 0) begin
            total++;
            if (rs2_d_o !== 5'd5 || rs1_d_o !== 5'd2 || funct3_d_o !== 3'd2 ||
                funct7_d_o !== 7'd0 || op_d_o !== 7'h23) begin
               bad++;
               $display("FAIL s_fields got rs2=%0d rs1=%0d f3=%0d f7=%0d op=%h",
                        rs2_d_o, rs1_d_o, funct3_d_o, funct7_d_o, op_d_o);
            end
         end
         drain();
      end
      imm_src_d_i = 3'd0;
   endtask

   task automatic test_fill();
      stall_d_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h0000_0013 | 32'(i << 7), 32'(i * 4));
         step();
      end
      total++;
      if (occupancy_o !== CNT_W'(DEPTH) || ready_f_o !== 1'b0) begin
         bad++; $display("FAIL fill got occ=%0d rdy=%b want=4/0", occupancy_o, ready_f_o);
      end
      drive(1'b1, 32'hBAD0_0013, 32'h10);
      step();
      drain();
      total++;
      if (sb.size() != 0 || instr_d_o !== '0 || pc_d_o !== '0 || imm_ext_d_o !== '0) begin
         bad++;
         $display("FAIL empty_zero got instr=%h pc=%h imm=%h left=%0d want 0",
                  instr_d_o, pc_d_o, imm_ext_d_o, sb.size());
      end
   endtask

   task automatic test_stream_wrap();
      stall_d_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'h0010_0093 + 32'(i << 20), 32'h1000 + 32'(i * 4));
         step();
         total++;
         if (occupancy_o !== CNT_W'(1)) begin
            bad++; $display("FAIL stream_occ[%0d] got=%0d want=1", i, occupancy_o);
         end
      end
      drain();
   endtask

   task automatic test_full_push_pop();
      stall_d_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 32'h0000_0113 + 32'(i << 20), 32'h2000 + 32'(i * 4));
         step();
      end
      stall_d_i = 1'b0;
      drive(1'b1, 32'hCAFE_0013, 32'h2100);
      step();
      drive(1'b0, 32'h0, 32'h0);
      total++;
      if (occupancy_o !== CNT_W'(3) || ready_f_o !== 1'b1) begin
         bad++; $display("FAIL full_pushpop got occ=%0d rdy=%b want=3/1", occupancy_o, ready_f_o);
      end
      drain();
   endtask

   task automatic test_flush();
      stall_d_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h0000_0193 + 32'(i << 20), 32'h3000 + 32'(i * 4));
         step();
      end
      flush_d_i = 1'b1;
      drive(1'b1, 32'hF1F1_0013, 32'h3100);
      step();
      flush_d_i = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      total++;
      if (valid_d_o !== 1'b0 || occupancy_o !== '0) begin
         bad++; $display("FAIL flush got vld=%b occ=%0d want=0/0", valid_d_o, occupancy_o);
      end
      drive(1'b1, 32'h0070_0213, 32'h3200);
      step();
      drive(1'b0, 32'h0, 32'h0);
      total++;
      if (pc_d_o !== 32'h3200 || occupancy_o !== CNT_W'(1)) begin
         bad++; $display("FAIL post_flush got pc=%h occ=%0d want=3200/1", pc_d_o, occupancy_o);
      end
      drain();
   endtask

   task automatic test_async_reset();
      stall_d_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 32'h0000_0293 + 32'(i << 20), 32'h4000 + 32'(i * 4));
         step();
      end
      drive(1'b0, 32'h0, 32'h0);
      #2;
      reset_n_i = 1'b0;
      #1;
      total++;
      if (valid_d_o !== 1'b0 || occupancy_o !== '0 || instr_d_o !== '0) begin
         bad++;
         $display("FAIL async_reset got vld=%b occ=%0d instr=%h want 0", valid_d_o, occupancy_o,
                  instr_d_o);
      end
      sb.delete();
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;
      stall_d_i = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_first_push();
      test_imm();
      test_fill();
      test_stream_wrap();
      test_full_push_pop();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
